// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with run-time pattern/length load,
// selectable overlap and a saturating match counter. Define SEQ_DETECT_MEALY_EN for a zero-latency combinational y.
module seq_detect_prog #(
  parameter int                 MAX_LEN = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1011),
  parameter int                 DEF_LEN = 4,
  parameter int                 CNT_W   = 8,
  localparam int                LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               x,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      len_in,
  input  logic               overlap,
  input  logic               clr_cnt,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LW-1:0]      fill
);

  typedef enum logic {FILL, ARMED} state_t;

  state_t             state, state_n;
  // The newest bit always completes the window, so only MAX_LEN-1 older bits are stored
  logic [MAX_LEN-2:0] hist, hist_n;
  logic [MAX_LEN-1:0] pat, nh, mask;
  logic [LW-1:0]      len, len_clamped, nf, fill_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               hit;

  always_comb begin
    len_clamped = len_in;
    if (len_in < LW'(2)) begin
      len_clamped = LW'(2);
    end else if (len_in > LW'(MAX_LEN)) begin
      len_clamped = LW'(MAX_LEN);
    end
  end

  // ARMED means the window is already full, so the fill count stops at len
  always_comb begin
    nh   = {hist, x};
    nf   = (state == ARMED) ? len : fill + LW'(1);
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = en && !load && (nf == len) && ((nh & mask) == (pat & mask));
  end

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    cnt_n   = cnt;
    if (load) begin
      state_n = FILL;
      hist_n  = '0;
      fill_n  = '0;
    end else if (en) begin
      if (hit && !overlap) begin
        state_n = FILL;
        hist_n  = '0;
        fill_n  = '0;
      end else begin
        hist_n  = nh[MAX_LEN-2:0];
        fill_n  = nf;
        state_n = (nf == len) ? ARMED : FILL;
      end
    end
    if (clr_cnt) begin
      cnt_n = '0;
    end else if (hit && (cnt != {CNT_W{1'b1}})) begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      hist  <= '0;
      fill  <= '0;
      cnt   <= '0;
      pat   <= DEF_PAT;
      len   <= LW'(DEF_LEN);
    end else begin
      state <= state_n;
      hist  <= hist_n;
      fill  <= fill_n;
      cnt   <= cnt_n;
      if (load) begin
        pat <= pat_in;
        len <= len_clamped;
      end
    end
  end

  assign match_cnt = cnt;

`ifdef SEQ_DETECT_MEALY_EN
  assign y = hit;
`else
  logic y_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q <= 1'b0;
    end else begin
      y_q <= hit;
    end
  end

  assign y = y_q;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog (registered-y build): a bit-queue reference
// model pushes expected outputs per clock, a negedge monitor pops and compares.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, x = 1'b0, load = 1'b0, overlap = 1'b1, clr_cnt = 1'b0;
  logic [7:0] pat_in = '0;
  logic [3:0] len_in = '0;
  logic       y;
  logic [7:0] match_cnt;
  logic [3:0] fill;

  typedef struct packed {
    logic       y;
    logic [7:0] cnt;
    logic [3:0] fill;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  bit         mhist[$];
  logic [7:0] mpat;
  int         mlen;
  int         mcnt;

  seq_detect_prog dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt), .y(y),
    .match_cnt(match_cnt), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mhist.delete();
    mpat = 8'h0B;
    mlen = 4;
    mcnt = 0;
  endtask

  // Reference: keep the last len received bits and compare them against the pattern, oldest first
  function automatic exp_t modelStep();
    exp_t e;
    bit   hitm = 1'b0;
    if (load) begin
      mpat = pat_in;
      mlen = (len_in < 2) ? 2 : ((len_in > 8) ? 8 : int'(len_in));
      mhist.delete();
    end else if (en) begin
      mhist.push_back(x);
      if (mhist.size() > mlen) void'(mhist.pop_front());
      if (mhist.size() == mlen) begin
        hitm = 1'b1;
        for (int i = 0; i < mlen; i++) begin
          if (mhist[i] != mpat[mlen-1-i]) hitm = 1'b0;
        end
      end
      if (hitm && !overlap) mhist.delete();
    end
    if (clr_cnt) mcnt = 0;
    else if (hitm && mcnt < 255) mcnt++;
    e.y    = hitm;
    e.cnt  = 8'(mcnt);
    e.fill = 4'(mhist.size());
    return e;
  endfunction

  task automatic applyStimulus(input logic e, input logic xi, input logic ld, input logic [7:0] p,
                               input logic [3:0] l, input logic ov, input logic clr);
    en = e; x = xi; load = ld; pat_in = p; len_in = l; overlap = ov; clr_cnt = clr;
    @(posedge clk);
    expq.push_back(modelStep());
    #1;
  endtask

  task automatic streamBits(input logic [15:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, bits[i], 1'b0, 8'h00, 4'h0, ov, 1'b0);
  endtask

  task automatic loadPattern(input logic [7:0] p, input logic [3:0] l, input logic clr);
    applyStimulus(1'b0, 1'b0, 1'b1, p, l, overlap, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, overlap, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && expq.size() > 0) begin
      e = expq.pop_front();
      checkOutput("sb_y", y, e.y);
      checkOutput("sb_match_cnt", match_cnt, e.cnt);
      checkOutput("sb_fill", fill, e.fill);
    end
  end

  initial begin
    int r;
    int drain;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    checkOutput("reset_y", y, 0);
    checkOutput("reset_cnt", match_cnt, 0);
    checkOutput("reset_fill", fill, 0);

    streamBits(16'b1011, 4, 1'b1);
    checkOutput("default_y", y, 1);
    checkOutput("default_cnt", match_cnt, 1);
    idle(1);
    checkOutput("default_y_one_cycle", y, 0);

    loadPattern(8'h0B, 4'd4, 1'b1);
    streamBits(16'b1011011, 7, 1'b1);
    checkOutput("overlap_cnt", match_cnt, 2);

    loadPattern(8'h0B, 4'd4, 1'b1);
    streamBits(16'b1011011, 7, 1'b0);
    checkOutput("nonoverlap_cnt", match_cnt, 1);
    checkOutput("nonoverlap_fill", fill, 3);

    overlap = 1'b1;
    loadPattern(8'hA5, 4'd8, 1'b1);
    streamBits(16'b10100101, 8, 1'b1);
    checkOutput("len8_y", y, 1);
    checkOutput("len8_cnt", match_cnt, 1);

    loadPattern(8'h03, 4'd0, 1'b0);
    streamBits(16'b0111, 4, 1'b1);
    checkOutput("clamp_low_fill", fill, 2);
    loadPattern(8'h00, 4'd15, 1'b0);
    streamBits(16'h0000, 10, 1'b1);
    checkOutput("clamp_high_fill", fill, 8);

    loadPattern(8'h0B, 4'd4, 1'b1);
    streamBits(16'b101, 3, 1'b1);
    loadPattern(8'h0B, 4'd4, 1'b0);
    streamBits(16'b1, 1, 1'b1);
    checkOutput("load_clears_hist_y", y, 0);
    checkOutput("load_clears_hist_fill", fill, 1);

    loadPattern(8'h0B, 4'd4, 1'b1);
    streamBits(16'b10, 2, 1'b1);
    idle(3);
    streamBits(16'b11, 2, 1'b1);
    checkOutput("en_gap_y", y, 1);

    loadPattern(8'h03, 4'd2, 1'b1);
    for (int i = 0; i < 300; i++) streamBits(16'b1, 1, 1'b1);
    checkOutput("saturate_cnt", match_cnt, 255);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
    checkOutput("clr_hit_y", y, 1);
    checkOutput("clr_hit_cnt", match_cnt, 0);
    streamBits(16'b1, 1, 1'b1);

    loadPattern(8'h0B, 4'd4, 1'b0);
    streamBits(16'b101, 3, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset_y", y, 0);
    checkOutput("async_reset_cnt", match_cnt, 0);
    checkOutput("async_reset_fill", fill, 0);
    #2 reset = 1'b1;
    streamBits(16'b1, 1, 1'b1);
    checkOutput("post_reset_no_match", y, 0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'b0);
      end else begin
        applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 8'($urandom),
                      4'($urandom), 1'($urandom), 1'(r >= 97));
      end
    end
    idle(1);

    drain = 0;
    while (expq.size() > 0 && drain < 5) begin
      @(posedge clk);
      drain++;
    end
    if (expq.size() > 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
